// File: rtl/path_unwinder.sv
`default_nettype none
// ============================================================================
//  Module   : path_unwinder
//  Purpose  : Pops every direction held in the 2-bit direction stack and walks
//             the path backwards from a supplied end cell. Each reconstructed
//             step goes to a downstream sink over a valid/ready handshake.
//             The block also reports a running step count and a one-cycle
//             completion pulse.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   system clock, rising edge
//    rst        in   asynchronous active-low reset
//    start      in   one-cycle request to unwind (ignored unless idle)
//    x_init     in   end-cell X, sampled when start is accepted
//    y_init     in   end-cell Y, sampled when start is accepted
//    stk_empty  in   stack empty flag
//    stk_data   in   stack pop data, valid the cycle after stk_pop
//    stk_pop    out  one-cycle pop request
//    mv_valid   out  step payload valid
//    mv_ready   in   sink ready
//    mv_dir     out  popped direction (00 up, 01 right, 10 down, 11 left)
//    mv_x/mv_y  out  cell reached after undoing mv_dir
//    busy       out  high whenever not idle
//    done       out  one-cycle completion pulse
//    count      out  steps popped since the last accepted start
// ============================================================================
module path_unwinder #(
    parameter int COORD_W = 4,
    parameter int CNT_W   = 9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [COORD_W-1:0] x_init,
    input  logic [COORD_W-1:0] y_init,
    input  logic               stk_empty,
    input  logic [1:0]         stk_data,
    output logic               stk_pop,
    output logic               mv_valid,
    input  logic               mv_ready,
    output logic [1:0]         mv_dir,
    output logic [COORD_W-1:0] mv_x,
    output logic [COORD_W-1:0] mv_y,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   count
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        LATCH = 3'd2,
        SEND  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [COORD_W-1:0] c_COORD_ONE = COORD_W'(1);
    localparam logic [CNT_W-1:0]   c_CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]   c_CNT_MAX   = {CNT_W{1'b1}};

    state_t               r_state;
    state_t               w_next;
    logic [1:0]           r_dir;
    logic [COORD_W-1:0]   r_x;
    logic [COORD_W-1:0]   r_y;
    logic [CNT_W-1:0]     r_count;
    logic                 w_pop;
    logic                 w_valid;
    logic                 w_busy;
    logic                 w_done;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and control outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_next  = r_state;
        w_pop   = 1'b0;
        w_valid = 1'b0;
        w_busy  = 1'b1;
        w_done  = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_busy = 1'b0;
                if (start) begin
                    w_next = CHECK;
                end
            end
            CHECK: begin
                // The pop is gated by the empty flag in the same cycle so an
                // empty stack is never popped.
                if (stk_empty) begin
                    w_next = DONE;
                end else begin
                    w_pop  = 1'b1;
                    w_next = LATCH;
                end
            end
            LATCH: begin
                w_next = SEND;
            end
            SEND: begin
                w_valid = 1'b1;
                if (mv_ready) begin
                    w_next = CHECK;
                end
            end
            DONE: begin
                w_done = 1'b1;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: coordinate reconstruction and step counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dir   <= 2'b00;
            r_x     <= '0;
            r_y     <= '0;
            r_count <= '0;
        end else begin
            if (r_state == IDLE && start) begin
                r_x     <= x_init;
                r_y     <= y_init;
                r_count <= '0;
            end else if (r_state == LATCH) begin
                r_dir <= stk_data;
                // Undo the recorded move; arithmetic wraps at the coordinate width.
                unique case (stk_data)
                    2'b00:   r_y <= r_y - c_COORD_ONE;
                    2'b01:   r_x <= r_x - c_COORD_ONE;
                    2'b10:   r_y <= r_y + c_COORD_ONE;
                    default: r_x <= r_x + c_COORD_ONE;
                endcase
                if (r_count != c_CNT_MAX) begin
                    r_count <= r_count + c_CNT_ONE;
                end
            end
        end
    end

    assign stk_pop  = w_pop;
    assign mv_valid = w_valid;
    assign busy     = w_busy;
    assign done     = w_done;
    assign mv_dir   = r_dir;
    assign mv_x     = r_x;
    assign mv_y     = r_y;
    assign count    = r_count;

endmodule
`default_nettype wire

// File: tb/tb_path_unwinder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_path_unwinder
//  Purpose  : Directed self-checking bench for path_unwinder. Contains a
//             small behavioural model of the 256 x 2-bit direction stack
//             (registered pop data, combinational empty flag).
//  Revision : 1.0  initial release
// ============================================================================
module tb_path_unwinder;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] x_init;
    logic [3:0] y_init;
    logic       stk_empty;
    logic [1:0] stk_data;
    logic       stk_pop;
    logic       mv_valid;
    logic       mv_ready;
    logic [1:0] mv_dir;
    logic [3:0] mv_x;
    logic [3:0] mv_y;
    logic       busy;
    logic       done;
    logic [8:0] count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    path_unwinder #(.COORD_W(4), .CNT_W(9)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .x_init    (x_init),
        .y_init    (y_init),
        .stk_empty (stk_empty),
        .stk_data  (stk_data),
        .stk_pop   (stk_pop),
        .mv_valid  (mv_valid),
        .mv_ready  (mv_ready),
        .mv_dir    (mv_dir),
        .mv_x      (mv_x),
        .mv_y      (mv_y),
        .busy      (busy),
        .done      (done),
        .count     (count)
    );

    // ------------------------------------------------------------------------
    // Stack model
    // ------------------------------------------------------------------------
    logic [1:0] mem [0:255];
    logic [8:0] sp = '0;
    logic       push_en = 1'b0;
    logic [1:0] push_d  = 2'b00;

    assign stk_empty = (sp == 9'd0);

    always @(posedge clk) begin
        if (push_en) begin
            mem[sp[7:0]] <= push_d;
            sp           <= sp + 9'd1;
        end else if (stk_pop && sp != 9'd0) begin
            stk_data <= mem[sp[7:0] - 8'd1];
            sp       <= sp - 9'd1;
        end
    end

    // ------------------------------------------------------------------------
    // Protocol monitors
    // ------------------------------------------------------------------------
    int   viol_empty = 0;
    int   viol_pend  = 0;
    logic pend;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend <= 1'b0;
        end else begin
            if (stk_pop && stk_empty) viol_empty <= viol_empty + 1;
            if (stk_pop) begin
                if (pend) viol_pend <= viol_pend + 1;
                pend <= 1'b1;
            end else if (mv_valid && mv_ready) begin
                pend <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] d);
        push_en = 1'b1;
        push_d  = d;
        step();
        push_en = 1'b0;
    endtask

    task automatic kick(input logic [3:0] x, input logic [3:0] y);
        start  = 1'b1;
        x_init = x;
        y_init = y;
        step();
        start  = 1'b0;
    endtask

    // Waits (bounded) for a presented step and checks its payload; if the
    // sink is ready the handshake edge is consumed as well.
    task automatic run_step(input string tag, input logic [1:0] d, input logic [3:0] x,
                            input logic [3:0] y, input logic [8:0] c);
        int n = 0;
        while (!mv_valid && n < 12) begin
            step();
            n++;
        end
        chk({tag, "_valid"}, 32'(mv_valid), 32'd1);
        chk({tag, "_dir"},   32'(mv_dir),   32'(d));
        chk({tag, "_x"},     32'(mv_x),     32'(x));
        chk({tag, "_y"},     32'(mv_y),     32'(y));
        chk({tag, "_count"}, 32'(count),    32'(c));
        if (mv_ready) step();
    endtask

    task automatic finish_run(input string tag, input logic [8:0] c, input logic [3:0] x,
                              input logic [3:0] y);
        int n = 0;
        while (!done && n < 12) begin
            step();
            n++;
        end
        chk({tag, "_done"},     32'(done),      32'd1);
        chk({tag, "_busy_dn"},  32'(busy),      32'd1);
        step();
        chk({tag, "_done_off"}, 32'(done),      32'd0);
        chk({tag, "_idle"},     32'(busy),      32'd0);
        chk({tag, "_count"},    32'(count),     32'(c));
        chk({tag, "_x_end"},    32'(mv_x),      32'(x));
        chk({tag, "_y_end"},    32'(mv_y),      32'(y));
        chk({tag, "_empty"},    32'(stk_empty), 32'd1);
    endtask

    // ------------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------------
    initial begin
        rst      = 1'b0;
        start    = 1'b0;
        x_init   = '0;
        y_init   = '0;
        mv_ready = 1'b0;
        step();
        step();
        chk("rst_pop",   32'(stk_pop),  32'd0);
        chk("rst_valid", 32'(mv_valid), 32'd0);
        chk("rst_done",  32'(done),     32'd0);
        chk("rst_busy",  32'(busy),     32'd0);
        chk("rst_dir",   32'(mv_dir),   32'd0);
        chk("rst_x",     32'(mv_x),     32'd0);
        chk("rst_y",     32'(mv_y),     32'd0);
        chk("rst_count", 32'(count),    32'd0);
        rst = 1'b1;
        step();

        // 1. Basic unwind with exact latency checks
        push(2'b01); push(2'b01); push(2'b00);
        mv_ready = 1'b1;
        kick(4'd2, 4'd1);
        chk("s1_pop_lat",   32'(stk_pop),  32'd1);
        chk("s1_busy",      32'(busy),     32'd1);
        step();
        chk("s1_pop_once",  32'(stk_pop),  32'd0);
        chk("s1_valid_lo",  32'(mv_valid), 32'd0);
        step();
        run_step("s1_a", 2'b00, 4'd2, 4'd0, 9'd1);
        run_step("s1_b", 2'b01, 4'd1, 4'd0, 9'd2);
        run_step("s1_c", 2'b01, 4'd0, 4'd0, 9'd3);
        chk("s1_last_pop",  32'(stk_pop),  32'd0);
        finish_run("s1", 9'd3, 4'd0, 4'd0);
        chk("s1_done_once", 32'(done),     32'd0);

        // 2. Empty stack
        kick(4'd5, 4'd7);
        chk("s2_pop",    32'(stk_pop),  32'd0);
        chk("s2_valid",  32'(mv_valid), 32'd0);
        chk("s2_done_e", 32'(done),     32'd0);
        step();
        chk("s2_done",   32'(done),     32'd1);
        chk("s2_pop2",   32'(stk_pop),  32'd0);
        step();
        chk("s2_idle",   32'(busy),     32'd0);
        chk("s2_count",  32'(count),    32'd0);
        chk("s2_x",      32'(mv_x),     32'd5);
        chk("s2_y",      32'(mv_y),     32'd7);

        // 3. Backpressure
        push(2'b10); push(2'b11);
        mv_ready = 1'b0;
        kick(4'd3, 4'd3);
        run_step("s3_a", 2'b11, 4'd4, 4'd3, 9'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("s3_hold_valid", 32'(mv_valid), 32'd1);
            chk("s3_hold_dir",   32'(mv_dir),   32'd3);
            chk("s3_hold_x",     32'(mv_x),     32'd4);
            chk("s3_hold_y",     32'(mv_y),     32'd3);
            chk("s3_hold_count", 32'(count),    32'd1);
            chk("s3_hold_pop",   32'(stk_pop),  32'd0);
        end
        mv_ready = 1'b1;
        step();
        chk("s3_pop_after", 32'(stk_pop), 32'd1);
        run_step("s3_b", 2'b10, 4'd4, 4'd4, 9'd2);
        finish_run("s3", 9'd2, 4'd4, 4'd4);

        // 4. Wrap-around
        push(2'b01); push(2'b00);
        kick(4'd0, 4'd0);
        run_step("s4_a", 2'b00, 4'd0,  4'd15, 9'd1);
        run_step("s4_b", 2'b01, 4'd15, 4'd15, 9'd2);
        finish_run("s4", 9'd2, 4'd15, 4'd15);

        // 5. Reset while a step is presented
        push(2'b00); push(2'b00); push(2'b00);
        mv_ready = 1'b0;
        kick(4'd5, 4'd5);
        run_step("s5_a", 2'b00, 4'd5, 4'd4, 9'd1);
        #2 rst = 1'b0;
        #1;
        chk("s5_valid_async", 32'(mv_valid), 32'd0);
        chk("s5_busy_async",  32'(busy),     32'd0);
        chk("s5_count_async", 32'(count),    32'd0);
        chk("s5_x_async",     32'(mv_x),     32'd0);
        step();
        rst = 1'b1;
        step();
        chk("s5_idle",        32'(busy),     32'd0);
        mv_ready = 1'b1;
        kick(4'd5, 4'd5);
        run_step("s5_b", 2'b00, 4'd5, 4'd4, 9'd1);
        run_step("s5_c", 2'b00, 4'd5, 4'd3, 9'd2);
        finish_run("s5", 9'd2, 4'd5, 4'd3);

        // 6. Start while busy is ignored
        push(2'b01); push(2'b01); push(2'b00);
        mv_ready = 1'b0;
        kick(4'd2, 4'd1);
        run_step("s6_a", 2'b00, 4'd2, 4'd0, 9'd1);
        kick(4'd9, 4'd9);
        chk("s6_still_valid", 32'(mv_valid), 32'd1);
        chk("s6_x_kept",      32'(mv_x),     32'd2);
        chk("s6_y_kept",      32'(mv_y),     32'd0);
        chk("s6_count_kept",  32'(count),    32'd1);
        mv_ready = 1'b1;
        step();
        run_step("s6_b", 2'b01, 4'd1, 4'd0, 9'd2);
        run_step("s6_c", 2'b01, 4'd0, 4'd0, 9'd3);
        finish_run("s6", 9'd3, 4'd0, 4'd0);

        // Protocol monitors over the whole run
        chk("pop_while_empty",  32'(viol_empty), 32'd0);
        chk("pop_no_handshake", 32'(viol_pend),  32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/path_unwinder.md
Name: path_unwinder

Overview:
- Downstream consumer of the 2-bit direction stack (256 x 2-bit, registered pop data).
- On a start pulse it pops every stored direction until the stack reports empty.
- It reconstructs the path backward from a supplied end coordinate and presents each step to a downstream sink over a valid/ready handshake.
- It reports the step count and a completion pulse.

Parameters:
COORD_W, 4, width of each X/Y coordinate; arithmetic wraps modulo 2^COORD_W
CNT_W, 9, width of step counter (covers 0..256 entries)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
start  input  1  one-cycle request to begin unwinding; ignored unless IDLE
x_init  input  COORD_W  end-cell X, sampled when start accepted
y_init  input  COORD_W  end-cell Y, sampled when start accepted
stk_empty  input  1  stack empty flag (combinational from stack pointer)
stk_data  input  2  stack data_out; valid on cycle after stk_pop asserted
stk_pop  output  1  pop request to stack, one-cycle pulse
mv_valid  output  1  step output valid
mv_ready  input  1  sink accepts step when high with mv_valid
mv_dir  output  2  popped direction: 00 up, 01 right, 10 down, 11 left
mv_x  output  COORD_W  cell X after undoing mv_dir
mv_y  output  COORD_W  cell Y after undoing mv_dir
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when unwinding completes
count  output  CNT_W  number of steps popped since last accepted start

Behaviour:
- Reset (rst=0, async) values:
  - State=IDLE.
  - stk_pop=0, mv_valid=0, done=0, busy=0.
  - mv_dir=00, mv_x=0, mv_y=0, count=0.
- States:
  - IDLE: on start=1, load mv_x=x_init, mv_y=y_init, clear count=0; next CHECK. Otherwise stay.
  - CHECK:
    - If stk_empty=1: next DONE; stk_pop stays 0.
    - Else: assert stk_pop=1 (combinational, this cycle only); next LATCH.
  - LATCH:
    - Register mv_dir<=stk_data.
    - Apply reverse move: 00 -> y-1; 01 -> x-1; 10 -> y+1; 11 -> x+1.
    - count<=count+1; next SEND.
  - SEND:
    - mv_valid=1.
    - mv_dir, mv_x, mv_y held stable until handshake.
    - On mv_valid & mv_ready: next CHECK. Else stay.
  - DONE: done=1 for exactly one cycle; next IDLE.
- Latency:
  - start edge -> first stk_pop 1 cycle later.
  - mv_valid rises 2 cycles after stk_pop.
  - Minimum 3 cycles per step with mv_ready held high.
- stk_pop is never asserted twice without an intervening completed handshake.
- stk_pop is never asserted while stk_empty=1.
- Coordinate arithmetic is modulo 2^COORD_W: 0-1 -> 2^COORD_W-1; max+1 -> 0.
- count saturates at 2^CNT_W-1; with default CNT_W=9 this is never reached.
- start while busy=1 is ignored: no reload, no count clear.
- Outputs persist in IDLE after completion:
  - mv_x/mv_y hold the start-of-path cell.
  - count holds the final value.
- Reset asserted mid-operation:
  - Immediate return to reset values.
  - Any pending mv_valid is dropped.
  - Stack contents are not restored (stack has its own reset).
- mv_ready while mv_valid=0 has no effect.

Test Plan:
1. Basic unwind:
   - Stimulus: push 01,01,00 (path (0,0)->(2,1)); start with x_init=2, y_init=1; mv_ready=1.
   - Required: steps dir/x/y = 00/(2,0), 01/(1,0), 01/(0,0).
   - Required: count=3; done pulses once; stk_empty=1 afterward.
2. Empty stack:
   - Stimulus: start with empty stack.
   - Required: stk_pop never high; done pulses 2 cycles after start; count=0; mv_valid never high.
3. Backpressure:
   - Stimulus: 2 entries, mv_ready=0 for 5 cycles after first mv_valid.
   - Required: mv_valid and payload held stable for all 5 cycles; no second stk_pop until handshake; count=1 during stall.
4. Wrap-around:
   - Stimulus: push 01 then 00; start with x_init=0, y_init=0.
   - Required: first step 00 -> (0,15); second step 01 -> (15,15).
5. Reset mid-SEND:
   - Stimulus: rst=0 while mv_valid=1.
   - Required: mv_valid, busy, count go to 0 asynchronously; after release, IDLE; start re-runs on remaining entries.
6. Start while busy:
   - Stimulus: pulse start with different x_init during SEND.
   - Required: mv_x/mv_y/count unaffected; sequence completes as in scenario 1.
